// File: rtl/pin_bank_pkg.sv
// pin_bank_pkg
// Shared definitions for the pin bank arbiter:
//   - register select encodings (LAT / TRIS / IOCMASK / IOCFLAG)
//   - arbiter FSM state enum
//   - default bank width
//   - round-robin tie-break helper
package pin_bank_pkg;

    localparam int DEFAULT_WIDTH = 13;

    localparam logic [1:0] SEL_LAT     = 2'd0;
    localparam logic [1:0] SEL_TRIS    = 2'd1;
    localparam logic [1:0] SEL_IOCMASK = 2'd2;
    localparam logic [1:0] SEL_IOCFLAG = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        DBG  = 2'd2
    } state_t;

    // CPU wins when it is eligible and either debug is not competing or
    // debug was not the loser of the previous grant (CPU did not win last).
    function automatic logic pick_cpu(input logic cpu_ok,
                                      input logic dbg_ok,
                                      input logic last_was_cpu);
        return cpu_ok & (~dbg_ok | ~last_was_cpu);
    endfunction

endpackage

// File: rtl/pin_sync.sv
// pin_sync
// WIDTH-wide two-flop synchronizer for asynchronous pad inputs.
// Ports:
//   i_clock  - sampling clock
//   i_reset  - synchronous active-high reset, clears both stages
//   i_d      - asynchronous pad data
//   o_q      - synchronized data (second stage)
module pin_sync #(
    parameter int WIDTH = 13
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage1;
    logic [WIDTH-1:0] r_stage2;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_stage1 <= '0;
            r_stage2 <= '0;
        end else begin
            r_stage1 <= i_d;
            r_stage2 <= r_stage1;
        end
    end

    assign o_q = r_stage2;

endmodule

// File: rtl/pin_bank_arbiter.sv
// pin_bank_arbiter
// Arbitrates CPU and debug access to a bank of WIDTH GPIO pins and holds the
// pin control registers (LAT, TRIS and, optionally, IOCMASK / IOCFLAG).
// Optional feature macro: PIN_BANK_IOC_EN enables interrupt-on-change
// (IOCMASK, IOCFLAG, ioc_irq). Without it sel 2/3 read 0, writes to them
// are granted but dropped, and ioc_irq is 0.
// Ports:
//   clock, reset                 - clock, synchronous active-high reset
//   cpu_req/we/sel/wdata         - CPU access request (held until cpu_gnt)
//   dbg_req/we/sel/wdata         - debug access request (held until dbg_gnt)
//   cpu_gnt, dbg_gnt             - one-cycle grant pulses
//   rdata                        - read data, valid in a read grant cycle
//   dbg_lock                     - blocks CPU grants while sampled high
//   pins_in / pins_out / pins_en - pad input, pad output data, output enable
//   ioc_irq                      - interrupt-on-change request
module pin_bank_arbiter
    import pin_bank_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [1:0]       cpu_sel,
    input  logic [WIDTH-1:0] cpu_wdata,
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [1:0]       dbg_sel,
    input  logic [WIDTH-1:0] dbg_wdata,
    output logic             cpu_gnt,
    output logic             dbg_gnt,
    output logic [WIDTH-1:0] rdata,
    input  logic             dbg_lock,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] pins_out,
    output logic [WIDTH-1:0] pins_en,
    output logic             ioc_irq
);

    state_t           r_state;
    logic             r_cpu_gnt;
    logic             r_dbg_gnt;
    logic             r_last_cpu;
    logic             r_we;
    logic [1:0]       r_sel;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_lat;
    logic [WIDTH-1:0] r_tris;

    logic [WIDTH-1:0] w_port;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_flag;
    logic             w_cpu_ok;
    logic             w_dbg_ok;
    logic             w_cpu_wins;
    logic             w_grant_active;
    logic             w_write;
    logic [WIDTH-1:0] w_rdata;

    pin_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .i_clock (clock),
        .i_reset (reset),
        .i_d     (pins_in),
        .o_q     (w_port)
    );

    assign w_cpu_ok   = cpu_req & ~dbg_lock;
    assign w_dbg_ok   = dbg_req;
    assign w_cpu_wins = pick_cpu(w_cpu_ok, w_dbg_ok, r_last_cpu);

    // Requests are only looked at in IDLE; the granted master's command is
    // captured so the grant cycle does not depend on the requester's inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cpu_gnt  <= 1'b0;
            r_dbg_gnt  <= 1'b0;
            r_last_cpu <= 1'b0;
            r_we       <= 1'b0;
            r_sel      <= SEL_LAT;
            r_wdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cpu_wins) begin
                        r_state    <= CPU;
                        r_cpu_gnt  <= 1'b1;
                        r_last_cpu <= 1'b1;
                        r_we       <= cpu_we;
                        r_sel      <= cpu_sel;
                        r_wdata    <= cpu_wdata;
                    end else if (w_dbg_ok) begin
                        r_state    <= DBG;
                        r_dbg_gnt  <= 1'b1;
                        r_last_cpu <= 1'b0;
                        r_we       <= dbg_we;
                        r_sel      <= dbg_sel;
                        r_wdata    <= dbg_wdata;
                    end
                end
                CPU, DBG: begin
                    r_state   <= IDLE;
                    r_cpu_gnt <= 1'b0;
                    r_dbg_gnt <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_cpu_gnt <= 1'b0;
                    r_dbg_gnt <= 1'b0;
                end
            endcase
        end
    end

    assign w_grant_active = (r_state != IDLE);
    assign w_write        = w_grant_active & r_we;

    // Writes land on the edge that ends the grant cycle; a reset on that
    // same edge takes priority, so the write is lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lat  <= '0;
            r_tris <= '1;
        end else if (w_write) begin
            if (r_sel == SEL_LAT)  r_lat  <= r_wdata;
            if (r_sel == SEL_TRIS) r_tris <= r_wdata;
        end
    end

`ifdef PIN_BANK_IOC_EN
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_flag;
    logic [WIDTH-1:0] r_prev;
    logic             r_irq;
    logic [WIDTH-1:0] w_ioc_set;
    logic [WIDTH-1:0] w_ioc_clr;

    // r_prev and the synchronizer both reset to 0, so no edge is seen on
    // the first cycle after reset regardless of the pad level.
    assign w_ioc_set = (w_port ^ r_prev) & r_tris & r_mask;
    assign w_ioc_clr = (w_write && (r_sel == SEL_IOCFLAG)) ? r_wdata : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mask <= '0;
            r_flag <= '0;
            r_prev <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_prev <= w_port;
            if (w_write && (r_sel == SEL_IOCMASK)) r_mask <= r_wdata;
            // Set is OR-ed after the clear so a coincident set survives.
            r_flag <= (r_flag & ~w_ioc_clr) | w_ioc_set;
            r_irq  <= |r_flag;
        end
    end

    assign w_mask  = r_mask;
    assign w_flag  = r_flag;
    assign ioc_irq = r_irq;
`else
    assign w_mask  = '0;
    assign w_flag  = '0;
    assign ioc_irq = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        if (w_grant_active && !r_we) begin
            case (r_sel)
                SEL_LAT:     w_rdata = w_port;
                SEL_TRIS:    w_rdata = r_tris;
                SEL_IOCMASK: w_rdata = w_mask;
                SEL_IOCFLAG: w_rdata = w_flag;
                default:     w_rdata = '0;
            endcase
        end
    end

    assign cpu_gnt  = r_cpu_gnt;
    assign dbg_gnt  = r_dbg_gnt;
    assign rdata    = w_rdata;
    assign pins_out = r_lat;
    assign pins_en  = ~r_tris;

endmodule

// File: tb/tb_pin_bank_arbiter.sv
module tb_pin_bank_arbiter;

    localparam int W = 13;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         cpu_req = 1'b0, cpu_we = 1'b0;
    logic [1:0]   cpu_sel = 2'd0;
    logic [W-1:0] cpu_wdata = '0;
    logic         dbg_req = 1'b0, dbg_we = 1'b0;
    logic [1:0]   dbg_sel = 2'd0;
    logic [W-1:0] dbg_wdata = '0;
    logic         dbg_lock = 1'b0;
    logic [W-1:0] pins_in = '0;
    logic         cpu_gnt, dbg_gnt, ioc_irq;
    logic [W-1:0] rdata, pins_out, pins_en;

    always #5 clock = ~clock;

    pin_bank_arbiter #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_sel   (cpu_sel),
        .cpu_wdata (cpu_wdata),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_sel   (dbg_sel),
        .dbg_wdata (dbg_wdata),
        .cpu_gnt   (cpu_gnt),
        .dbg_gnt   (dbg_gnt),
        .rdata     (rdata),
        .dbg_lock  (dbg_lock),
        .pins_in   (pins_in),
        .pins_out  (pins_out),
        .pins_en   (pins_en),
        .ioc_irq   (ioc_irq)
    );

    int n_pass = 0;
    int n_fail = 0;

    // Reference model: who holds the grant this cycle (0 none, 1 CPU, 2 debug),
    // the granted command, the register contents and the synchronizer pipe.
    int           m_gnt;
    bit           m_last_cpu;
    logic         m_g_we;
    logic [1:0]   m_g_sel;
    logic [W-1:0] m_g_wd;
    logic [W-1:0] m_lat, m_tris, m_mask, m_flag, m_s1, m_s2, m_prev;
    logic         m_irq;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] exp_rd;
        exp_rd = '0;
        if (m_gnt != 0 && !m_g_we) begin
            case (m_g_sel)
                2'd0: exp_rd = m_s2;
                2'd1: exp_rd = m_tris;
                2'd2: exp_rd = m_mask;
                default: exp_rd = m_flag;
            endcase
        end
        chk("model_cpu_gnt", cpu_gnt, (m_gnt == 1));
        chk("model_dbg_gnt", dbg_gnt, (m_gnt == 2));
        chk("model_rdata", rdata, exp_rd);
        chk("model_pins_out", pins_out, m_lat);
        chk("model_pins_en", pins_en, ~m_tris);
        chk("model_ioc_irq", ioc_irq, m_irq);
    endtask

    // Advance one clock: compute the model's next state from the inputs seen
    // at the edge, then compare the DUT shortly after the edge.
    task automatic step();
        int           ng;
        bit           nlast;
        logic         nwe;
        logic [1:0]   nsel;
        logic [W-1:0] nwd, nl, nt, nm, nf, clr;
        logic         ni;
        if (reset) begin
            ng = 0; nlast = 1'b0; nwe = 1'b0; nsel = 2'd0; nwd = '0;
            nl = '0; nt = '1; nm = '0; nf = '0; ni = 1'b0;
            @(posedge clock);
            #1;
            m_s1 = '0; m_s2 = '0; m_prev = '0;
        end else begin
            nl = m_lat; nt = m_tris; nm = m_mask; nf = m_flag; ni = m_irq; clr = '0;
            if (m_gnt != 0 && m_g_we) begin
                case (m_g_sel)
                    2'd0: nl = m_g_wd;
                    2'd1: nt = m_g_wd;
`ifdef PIN_BANK_IOC_EN
                    2'd2: nm = m_g_wd;
                    default: clr = m_g_wd;
`else
                    default: ;
`endif
                endcase
            end
`ifdef PIN_BANK_IOC_EN
            nf = (m_flag & ~clr) | ((m_s2 ^ m_prev) & m_tris & m_mask);
            ni = |m_flag;
`endif
            ng = 0; nlast = m_last_cpu; nwe = m_g_we; nsel = m_g_sel; nwd = m_g_wd;
            if (m_gnt == 0) begin
                if (cpu_req && !dbg_lock && (!dbg_req || !m_last_cpu)) begin
                    ng = 1; nlast = 1'b1; nwe = cpu_we; nsel = cpu_sel; nwd = cpu_wdata;
                end else if (dbg_req) begin
                    ng = 2; nlast = 1'b0; nwe = dbg_we; nsel = dbg_sel; nwd = dbg_wdata;
                end
            end
            m_prev = m_s2; m_s2 = m_s1; m_s1 = pins_in;
            @(posedge clock);
            #1;
        end
        m_gnt = ng; m_last_cpu = nlast; m_g_we = nwe; m_g_sel = nsel; m_g_wd = nwd;
        m_lat = nl; m_tris = nt; m_mask = nm; m_flag = nf; m_irq = ni;
        check_outputs();
    endtask

    // Raise a request, hold it until the model grants it (bounded), check
    // the DUT grant, then drop the request. Returns in the grant cycle.
    task automatic xact(input int who, input logic we, input logic [1:0] sel,
                        input logic [W-1:0] wd);
        if (who == 1) begin
            cpu_req = 1'b1; cpu_we = we; cpu_sel = sel; cpu_wdata = wd;
        end else begin
            dbg_req = 1'b1; dbg_we = we; dbg_sel = sel; dbg_wdata = wd;
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (m_gnt == who) break;
        end
        if (who == 1) begin
            chk("xact_cpu_gnt", cpu_gnt, 1'b1);
            cpu_req = 1'b0;
        end else begin
            chk("xact_dbg_gnt", dbg_gnt, 1'b1);
            dbg_req = 1'b0;
        end
    endtask

    initial begin
        bit exp_c[6];
        bit exp_d[6];
        int dbg_pulses;
        bit seen;
        exp_c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_d = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_cpu_gnt", cpu_gnt, 1'b0);
        chk("rst_dbg_gnt", dbg_gnt, 1'b0);
        chk("rst_rdata", rdata, '0);
        chk("rst_pins_out", pins_out, '0);
        chk("rst_pins_en", pins_en, '0);
        chk("rst_ioc_irq", ioc_irq, 1'b0);

        // Both requesting at a continuous level: CPU, DBG, CPU, two apart
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_sel = 2'd1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_sel = 2'd1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_cpu_gnt", cpu_gnt, exp_c[i]);
            chk("rr_dbg_gnt", dbg_gnt, exp_d[i]);
            if (exp_c[i] || exp_d[i]) chk("rr_rdata_tris", rdata, 13'h1FFF);
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        step();

        // Debug lock: only debug is granted; release lets CPU in quickly
        dbg_lock = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1;
        dbg_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("lock_cpu_gnt", cpu_gnt, 1'b0);
            if (dbg_gnt) dbg_pulses++;
        end
        chk("lock_dbg_pulses", dbg_pulses[W-1:0], 13'd3);
        dbg_req = 1'b0; dbg_lock = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (cpu_gnt) begin
                seen = 1'b1;
                break;
            end
        end
        chk("unlock_cpu_gnt", seen, 1'b1);
        cpu_req = 1'b0;
        step();

        // TRIS=0 then LAT=0x1555
        xact(1, 1'b1, 2'd1, 13'h0000);
        xact(1, 1'b1, 2'd0, 13'h1555);
        step();
        chk("wr_pins_out", pins_out, 13'h1555);
        chk("wr_pins_en", pins_en, 13'h1FFF);

        // Synchronized port read
        pins_in = 13'h0003;
        step();
        step();
        xact(1, 1'b0, 2'd0, '0);
        chk("port_read", rdata, 13'h0003);
        step();

`ifdef PIN_BANK_IOC_EN
        xact(1, 1'b1, 2'd1, 13'h1FFF);
        xact(1, 1'b1, 2'd2, 13'h0001);
        step();
        pins_in = 13'h0002;
        for (int i = 0; i < 4; i++) step();
        chk("ioc_irq_set", ioc_irq, 1'b1);
        xact(2, 1'b0, 2'd3, '0);
        chk("ioc_flag_read", rdata, 13'h0001);
        xact(2, 1'b1, 2'd3, 13'h0001);
        step();
        step();
        chk("ioc_irq_clr", ioc_irq, 1'b0);
        pins_in = 13'h0003;
        step();
        xact(1, 1'b1, 2'd3, 13'h0001);
        step();
        step();
        chk("ioc_set_wins_irq", ioc_irq, 1'b1);
        xact(1, 1'b0, 2'd3, '0);
        chk("ioc_set_wins_flag", rdata, 13'h0001);
        step();
`else
        xact(1, 1'b1, 2'd2, 13'h1FFF);
        xact(1, 1'b0, 2'd2, '0);
        chk("noioc_mask_read", rdata, '0);
        xact(2, 1'b0, 2'd3, '0);
        chk("noioc_flag_read", rdata, '0);
        step();
        chk("noioc_irq", ioc_irq, 1'b0);
`endif

        // Reset in the middle of a debug write grant to LAT
        xact(2, 1'b1, 2'd0, 13'h1FFF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstgnt_pins_out", pins_out, '0);
        chk("rstgnt_pins_en", pins_en, '0);
        chk("rstgnt_dbg_gnt", dbg_gnt, 1'b0);
        chk("rstgnt_cpu_gnt", cpu_gnt, 1'b0);
        chk("rstgnt_rdata", rdata, '0);
        chk("rstgnt_ioc_irq", ioc_irq, 1'b0);
        step();
        chk("rstgnt_pins_out_later", pins_out, '0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (!cpu_req && $urandom_range(0, 3) == 0) begin
                cpu_req = 1'b1;
                cpu_we = 1'($urandom_range(0, 1));
                cpu_sel = 2'($urandom_range(0, 3));
                cpu_wdata = W'($urandom);
            end
            if (!dbg_req && $urandom_range(0, 3) == 0) begin
                dbg_req = 1'b1;
                dbg_we = 1'($urandom_range(0, 1));
                dbg_sel = 2'($urandom_range(0, 3));
                dbg_wdata = W'($urandom);
            end
            if ($urandom_range(0, 7) == 0) dbg_lock = ~dbg_lock;
            if ($urandom_range(0, 3) == 0) pins_in = W'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            step();
            reset = 1'b0;
            if (m_gnt == 1) cpu_req = 1'b0;
            if (m_gnt == 2) dbg_req = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule

// File: doc/pin_bank_arbiter.md
PIN_BANK_ARBITER -- requirements
Module: pin_bank_arbiter

Interface
REQ-001 Parameter: WIDTH, default 13, number of pins in the bank.
REQ-002 Port: clock  in  1  sole clock, all state rising-edge.
REQ-003 Port: reset  in  1  synchronous reset, active-high.
REQ-004 Ports: cpu_req / dbg_req  in  1  access request, held until the matching grant.
REQ-005 Ports: cpu_we / dbg_we  in  1  write (1) or read (0).
REQ-006 Ports: cpu_sel / dbg_sel  in  2  register select: 0 LAT, 1 TRIS, 2 IOCMASK, 3 IOCFLAG.
REQ-007 Ports: cpu_wdata / dbg_wdata  in  WIDTH  write data.
REQ-008 Ports: cpu_gnt / dbg_gnt  out  1  one-cycle grant pulse.
REQ-009 Port: rdata  out  WIDTH  read data, valid during the grant cycle.
REQ-010 Port: dbg_lock  in  1  debug owns the bank; CPU requests are not granted.
REQ-011 Ports: pins_in  in  WIDTH / pins_out  out  WIDTH / pins_en  out  WIDTH  pad-side data in, data out, output enable.
REQ-012 Port: ioc_irq  out  1  interrupt-on-change request.

Function
REQ-013 The FSM SHALL have states IDLE, CPU, DBG; a grant asserts only in CPU or DBG, for exactly one cycle, then returns to IDLE.
REQ-014 Requests are sampled in IDLE: a request sampled in cycle N produces its grant in cycle N+1, and the next grant occurs no earlier than N+3.
REQ-015 Simultaneous eligible requests SHALL be resolved round-robin; the winner of the last grant loses the tie; CPU wins the first tie after reset.
REQ-016 While dbg_lock=1 sampled in IDLE, cpu_req SHALL be ignored; dbg_lock SHALL NOT abort a grant already issued.
REQ-017 Writes SHALL update the selected register on the clock edge ending the grant cycle; pins_out and pins_en reflect the write from cycle N+2.
REQ-018 pins_out SHALL equal LAT, and pins_en SHALL equal ~TRIS (TRIS bit 1 = input).
REQ-019 pins_in SHALL pass a 2-flop synchronizer; PORT value = synchronizer stage 2.
REQ-020 Read data SHALL be, per sel: 0 → synchronized PORT, 1 → TRIS, 2 → IOCMASK, 3 → IOCFLAG; rdata is 0 outside grant cycles.
REQ-021 A write to IOCFLAG SHALL clear the bits written as 1 (write-1-to-clear).
REQ-022 An IOCFLAG bit SHALL set when the synchronized bit differs from its previous-cycle value while the TRIS bit and the IOCMASK bit are both 1.
REQ-023 If a flag set and a W1C clear hit the same bit in the same cycle, the set SHALL win.
REQ-024 ioc_irq SHALL equal the OR of IOCFLAG, registered (one cycle after the flag sets).

Reset
REQ-025 On reset: state=IDLE; LAT=0; TRIS=all 1; IOCMASK=0; IOCFLAG=0; synchronizer=0; round-robin favours CPU; all grants, rdata, pins_out, pins_en and ioc_irq = 0.
REQ-026 Reset during a grant cycle SHALL discard the write, and the grant SHALL deassert on the following cycle.
REQ-027 The first cycle after reset SHALL NOT set any IOCFLAG bit from synchronizer fill.

Configuration
REQ-028 Macro PIN_BANK_IOC_EN defined: REQ-021..REQ-024 apply.
REQ-029 PIN_BANK_IOC_EN undefined: IOCMASK and IOCFLAG are not implemented; sel 2/3 read 0, writes to them are ignored but still granted; ioc_irq is tied 0.

Structure
REQ-030 Shared package pin_bank_pkg SHALL hold the sel encodings (LAT/TRIS/IOCMASK/IOCFLAG), the FSM state enum and the default WIDTH constant.
REQ-031 The synchronizer SHALL be a sub-module, pin_sync (WIDTH-wide, 2-flop, synchronous reset).

Verification
REQ-032 CPU write TRIS=0x0000, then LAT=0x1555 → pins_en=0x1FFF and pins_out=0x1555 from grant+1 cycle.
REQ-033 cpu_req and dbg_req asserted together at a continuous level → grants CPU, DBG, CPU, spaced 2 cycles apart.
REQ-034 dbg_lock=1 with both requesting → only dbg_gnt pulses; releasing the lock → cpu_gnt within 2 cycles.
REQ-035 pins_in=0x0003, CPU read sel=0 → rdata=0x0003 if the read is granted ≥2 cycles after the input changes.
REQ-036 With PIN_BANK_IOC_EN: IOCMASK=0x0001, toggle pins_in[0] → IOCFLAG=0x0001, ioc_irq=1; W1C 0x0001 → ioc_irq=0; a toggle coinciding with the clear keeps the flag set.
REQ-037 Assert reset during a dbg write grant of LAT=0x1FFF → LAT stays 0 and all outputs are at their reset values.
